// File: rtl/mycpu_pkg.sv
// Shared types for the 16-bit core control path: function-select codes,
// control sub-opcodes, sequencer states, instruction field positions and
// the decoded-instruction record.
// Optional build macro: MYCPU_MUL_2CYC_EN adds the S_EXEC2 state for FMUL.
package mycpu_pkg;

   typedef enum logic [3:0] {
      FMOVA = 4'h0, FINC  = 4'h1, FADD  = 4'h2, FSUB  = 4'h5,
      FDEC  = 4'h6, FAND  = 4'h8, FOR   = 4'h9, FXOR  = 4'hA,
      FNOT  = 4'hB, FMOVB = 4'hC, FSHR  = 4'hD, FSHL  = 4'hE,
      FMUL  = 4'hF
   } fs_t;

   typedef enum logic [2:0] {
      SUB_BZ   = 3'd0,
      SUB_BN   = 3'd1,
      SUB_JMP  = 3'd2,
      SUB_LDI  = 3'd3,
      SUB_HALT = 3'd4
   } ctrl_sub_t;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
`ifdef MYCPU_MUL_2CYC_EN
      S_EXEC2  = 3'd3,
`endif
      S_HALT   = 3'd4
   } ctrl_state_t;

   localparam int OP_BIT  = 15;
   localparam int FS_HI   = 14;
   localparam int FS_LO   = 11;
   localparam int DA_HI   = 10;
   localparam int DA_LO   = 8;
   localparam int AA_HI   = 7;
   localparam int AA_LO   = 5;
   localparam int BA_HI   = 4;
   localparam int BA_LO   = 2;
   localparam int SUB_HI  = 14;
   localparam int SUB_LO  = 12;
   localparam int LDA_HI  = 11;
   localparam int LDA_LO  = 9;
   localparam int IMM_HI  = 7;
   localparam int OFF_HI  = 8;

   typedef struct packed {
      logic        is_alu;
      logic        is_mul;
      logic [2:0]  sub;
      logic [3:0]  fs;
      logic [2:0]  da;
      logic [2:0]  aa;
      logic [2:0]  ba;
      logic        mb_sel;
      logic [15:0] imm;
      logic        wr;
      logic [8:0]  off;
   } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: IR word -> datapath selects and
// control class. Non-writing control ops leave all selects at zero.
module ctrl_decode
   import mycpu_pkg::*;
(
   input  logic [15:0] ir,
   output dec_t        dec
);

   // field extraction for both instruction classes
   always_comb begin
      dec        = '0;
      dec.off    = ir[OFF_HI:0];
      dec.sub    = ir[SUB_HI:SUB_LO];
      if (!ir[OP_BIT]) begin
         dec.is_alu = 1'b1;
         dec.fs     = ir[FS_HI:FS_LO];
         dec.da     = ir[DA_HI:DA_LO];
         dec.aa     = ir[AA_HI:AA_LO];
         dec.ba     = ir[BA_HI:BA_LO];
         dec.wr     = 1'b1;
         dec.is_mul = (ir[FS_HI:FS_LO] == FMUL);
      end else if (ir[SUB_HI:SUB_LO] == SUB_LDI) begin
         dec.fs     = FMOVB;
         dec.da     = ir[LDA_HI:LDA_LO];
         dec.mb_sel = 1'b1;
         dec.imm    = {8'h00, ir[IMM_HI:0]};
         dec.wr     = 1'b1;
      end
   end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetch over req/rdy, decode, execute.
// Owns PC, IR, flag register and the registered datapath controls.
// Optional build macro: MYCPU_MUL_2CYC_EN gives FMUL a second execute cycle.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_FETCH  | imem_req high at PC; wait for imem_rdy, latch IR, PC+1
//  S_DECODE | selects/fs/imm valid from IR, no write
//  S_EXEC   | write strobe + flag capture, or branch/jump/halt resolve
//  S_EXEC2  | second FMUL cycle (MYCPU_MUL_2CYC_EN only): write + flags
//  S_HALT   | stopped until reset
module cpu_ctrl_seq
   import mycpu_pkg::*;
#(
   parameter int              PC_W   = 8,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rdy,
   input  logic [15:0]     imem_data,
   output logic [3:0]      fs_out,
   output logic [2:0]      da,
   output logic [2:0]      aa,
   output logic [2:0]      ba,
   output logic            mb_sel,
   output logic [15:0]     imm_out,
   output logic            rf_we,
   input  logic            z_in,
   input  logic            n_in,
   output logic            flag_z,
   output logic            flag_n,
   output logic            halted
);

   ctrl_state_t     state;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;
   logic            we_q;
   dec_t            dec;
   logic [15:0]     off16;

   // Decode the incoming word while fetching so controls register on accept
   ctrl_decode u_dec (
      .ir  ((state == S_FETCH) ? imem_data : ir),
      .dec (dec)
   );

   assign off16 = {{7{dec.off[8]}}, dec.off};

   // Sequencer, PC/IR/flags and registered datapath controls
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         pc      <= RST_PC;
         ir      <= '0;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
         we_q    <= 1'b0;
         fs_out  <= '0;
         da      <= '0;
         aa      <= '0;
         ba      <= '0;
         mb_sel  <= 1'b0;
         imm_out <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_rdy) begin
                  ir      <= imem_data;
                  pc      <= pc + PC_W'(1);
                  state   <= S_DECODE;
                  fs_out  <= dec.fs;
                  da      <= dec.da;
                  aa      <= dec.aa;
                  ba      <= dec.ba;
                  mb_sel  <= dec.mb_sel;
                  imm_out <= dec.imm;
               end
            end
            S_DECODE: begin
               state <= S_EXEC;
`ifdef MYCPU_MUL_2CYC_EN
               we_q  <= dec.wr & ~dec.is_mul;
`else
               we_q  <= dec.wr;
`endif
            end
            S_EXEC: begin
               we_q  <= 1'b0;
               state <= S_FETCH;
`ifdef MYCPU_MUL_2CYC_EN
               if (dec.is_alu && dec.is_mul) begin
                  state <= S_EXEC2;
                  we_q  <= 1'b1;
               end else
`endif
               begin
                  fs_out  <= '0;
                  da      <= '0;
                  aa      <= '0;
                  ba      <= '0;
                  mb_sel  <= 1'b0;
                  imm_out <= '0;
                  if (dec.is_alu) begin
                     flag_z <= z_in;
                     flag_n <= n_in;
                  end else begin
                     case (dec.sub)
                        SUB_BZ:   if (flag_z) pc <= pc + off16[PC_W-1:0];
                        SUB_BN:   if (flag_n) pc <= pc + off16[PC_W-1:0];
                        SUB_JMP:  pc <= pc + off16[PC_W-1:0];
                        SUB_HALT: state <= S_HALT;
                        default:  ;
                     endcase
                  end
               end
            end
`ifdef MYCPU_MUL_2CYC_EN
            S_EXEC2: begin
               flag_z  <= z_in;
               flag_n  <= n_in;
               we_q    <= 1'b0;
               state   <= S_FETCH;
               fs_out  <= '0;
               da      <= '0;
               aa      <= '0;
               ba      <= '0;
               mb_sel  <= 1'b0;
               imm_out <= '0;
            end
`endif
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Reset in the same cycle suppresses a pending write strobe
   assign rf_we     = we_q & ~reset;
   assign imem_req  = (state == S_FETCH);
   assign imem_addr = pc;
   assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: expected fetch addresses and register
// writes are queued by the stimulus; a negedge monitor checks them as the
// DUT presents fetch accepts and write strobes.
module tb_cpu_ctrl_seq;
   import mycpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_rdy = 1'b0;
   logic [15:0] imem_data;
   logic [3:0]  fs_out;
   logic [2:0]  da, aa, ba;
   logic        mb_sel;
   logic [15:0] imm_out;
   logic        rf_we;
   logic        z_in = 1'b0, n_in = 1'b0;
   logic        flag_z, flag_n, halted;

   logic [15:0] mem [256];
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   cpu_ctrl_seq dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdy(imem_rdy), .imem_data(imem_data), .fs_out(fs_out),
      .da(da), .aa(aa), .ba(ba), .mb_sel(mb_sel), .imm_out(imm_out),
      .rf_we(rf_we), .z_in(z_in), .n_in(n_in), .flag_z(flag_z),
      .flag_n(flag_n), .halted(halted)
   );

   typedef struct packed {
      logic [3:0]  fs;
      logic [2:0]  da, aa, ba;
      logic        mb;
      logic [15:0] imm;
      logic [7:0]  lat;
   } wr_t;

   logic [7:0] exp_fetch [$];
   wr_t        exp_wr [$];
   int n_vec = 0, n_fail = 0;
   int cyc = 0, acc_cyc = 0;

`ifdef MYCPU_MUL_2CYC_EN
   localparam int MUL_LAT = 4;
`else
   localparam int MUL_LAT = 3;
`endif

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      n_vec++;
      n_fail++;
      $display("FAIL %s: actual 0x%0h required no event (t=%0t)", name, act, $time);
   endtask

   function automatic logic [15:0] alu(input logic [3:0] f, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
      return {1'b0, f, d, a, b, 2'b00};
   endfunction

   function automatic wr_t wr(input logic [3:0] f, input logic [2:0] d, input logic [2:0] a,
                              input logic [2:0] b, input logic m, input logic [15:0] i,
                              input int l);
      wr_t r;
      r.fs = f; r.da = d; r.aa = a; r.ba = b; r.mb = m; r.imm = i; r.lat = 8'(l);
      return r;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: fetch accepts and write strobes against the queues
   always @(negedge clk) begin
      if (!reset) begin
         if (imem_req && imem_rdy) begin
            acc_cyc = cyc;
            if (exp_fetch.size() == 0) unexpected("fetch_addr", int'(imem_addr));
            else chk("fetch_addr", int'(imem_addr), int'(exp_fetch.pop_front()));
         end
         if (rf_we) begin
            if (exp_wr.size() == 0) unexpected("rf_we", int'(da));
            else begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("wr_fs",  int'(fs_out),  int'(e.fs));
               chk("wr_da",  int'(da),      int'(e.da));
               chk("wr_aa",  int'(aa),      int'(e.aa));
               chk("wr_ba",  int'(ba),      int'(e.ba));
               chk("wr_mb",  int'(mb_sel),  int'(e.mb));
               chk("wr_imm", int'(imm_out), int'(e.imm));
               chk("wr_lat", cyc - acc_cyc + 1, int'(e.lat));
            end
         end
      end
   end

   task automatic clear_mem;
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
   endtask

   task automatic start(input logic rdy);
      reset = 1'b1;
      imem_rdy = rdy;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_to_halt(input logic ez, input logic en);
      int i;
      i = 0;
      while (!halted && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk("halted", int'(halted), 1);
      repeat (5) @(negedge clk);
      chk("halt_no_req", int'(imem_req), 0);
      chk("flag_z", int'(flag_z), int'(ez));
      chk("flag_n", int'(flag_n), int'(en));
      chk("fetch_q_left", exp_fetch.size(), 0);
      chk("wr_q_left", exp_wr.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values, fetch stall, LDI and PC wrap via jumps
      clear_mem();
      mem[8'h00] = 16'hA00F;   // JMP +15  -> 0x10
      mem[8'h10] = 16'hB8A5;   // LDI r4,0xA5
      mem[8'h11] = 16'hA1ED;   // JMP -19  -> 0xFF
      mem[8'hFF] = 16'hA001;   // JMP +1   -> 0x01 (wrap)
      z_in = 1'b1; n_in = 1'b1;
      reset = 1'b1; imem_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_we", int'(rf_we), 0);
      chk("rst_fs", int'(fs_out), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_flags", int'({flag_z, flag_n}), 0);
      chk("rst_addr", int'(imem_addr), 0);
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_req", int'(imem_req), 1);
         chk("stall_addr", int'(imem_addr), 0);
         chk("stall_fs", int'(fs_out), 0);
      end
      exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h10);
      exp_fetch.push_back(8'h11); exp_fetch.push_back(8'hFF);
      exp_fetch.push_back(8'h01);
      exp_wr.push_back(wr(FMOVB, 3'd4, 3'd0, 3'd0, 1'b1, 16'h00A5, 3));
      @(posedge clk); #1 imem_rdy = 1'b1;
      run_to_halt(1'b0, 1'b0);

      // FADD/FSUB with z=1, BZ -2 at PC 5 taken -> 4
      clear_mem();
      mem[0] = alu(FADD, 3'd1, 3'd2, 3'd3);
      mem[1] = alu(FSUB, 3'd4, 3'd5, 3'd6);
      mem[2] = 16'hD000;       // NOP
      mem[3] = 16'hA001;       // JMP +1 -> 5
      mem[5] = 16'h81FE;       // BZ -2
      z_in = 1'b1; n_in = 1'b0;
      foreach (exp_fetch[i]) ;
      exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd1); exp_fetch.push_back(8'd2);
      exp_fetch.push_back(8'd3); exp_fetch.push_back(8'd5); exp_fetch.push_back(8'd4);
      exp_wr.push_back(wr(FADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 3));
      exp_wr.push_back(wr(FSUB, 3'd4, 3'd5, 3'd6, 1'b0, 16'h0, 3));
      start(1'b1);
      run_to_halt(1'b1, 1'b0);

      // Same program with z=0 -> BZ not taken, falls through to 6
      z_in = 1'b0; n_in = 1'b1;
      exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd1); exp_fetch.push_back(8'd2);
      exp_fetch.push_back(8'd3); exp_fetch.push_back(8'd5); exp_fetch.push_back(8'd6);
      exp_wr.push_back(wr(FADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 3));
      exp_wr.push_back(wr(FSUB, 3'd4, 3'd5, 3'd6, 1'b0, 16'h0, 3));
      start(1'b1);
      run_to_halt(1'b0, 1'b1);

      // Reset during S_EXEC of FADD: no strobe, no flag capture, restart at 0
      clear_mem();
      mem[0] = alu(FADD, 3'd1, 3'd2, 3'd3);
      z_in = 1'b1; n_in = 1'b0;
      exp_fetch.push_back(8'd0);
      start(1'b1);
      begin
         int i;
         i = 0;
         while (fs_out != FADD && i < 20) begin
            @(negedge clk);
            i++;
         end
         chk("decode_seen", int'(fs_out), int'(FADD));
      end
      @(posedge clk); #1 reset = 1'b1;
      #1 chk("rst_exec_we", int'(rf_we), 0);
      @(posedge clk); #1;
      chk("rst_exec_flag_z", int'(flag_z), 0);
      exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd1);
      exp_wr.push_back(wr(FADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 3));
      reset = 1'b0;
      run_to_halt(1'b1, 1'b0);

      // FMUL latency (3 single-cycle, 4 with the two-cycle multiply build)
      clear_mem();
      mem[0] = alu(FMUL, 3'd7, 3'd1, 3'd2);
      z_in = 1'b0; n_in = 1'b1;
      exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd1);
      exp_wr.push_back(wr(FMUL, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0, MUL_LAT));
      start(1'b1);
      run_to_halt(1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
